// File: rtl/v810_intc.sv
// rtl/v810_intc.sv - V810 interrupt/exception controller and system-register file
module v810_intc (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        NMIn,
    input  logic        INT,
    input  logic [3:0]  INTVn,
    input  logic        BOUNDARY,
    input  logic [31:0] CUR_PC,
    input  logic        SR_WE,
    input  logic [4:0]  SR_ADDR,
    input  logic [31:0] SR_WDATA,
    output logic [31:0] SR_RDATA,
    input  logic        RETI,
    output logic [31:0] RETI_PC,
    output logic        TAKE,
    output logic [31:0] VECTOR,
    output logic [31:0] PSW
);

    // Only ID, AE, EP, NP and the I mask level exist in PSW.
    localparam logic [31:0] PSW_MASK = 32'h000F_F000;
    localparam int ID_BIT = 12;
    localparam int AE_BIT = 13;
    localparam int EP_BIT = 14;
    localparam int NP_BIT = 15;

    logic [31:0] psw_q,   psw_d;
    logic [31:0] eipc_q,  eipc_d;
    logic [31:0] eipsw_q, eipsw_d;
    logic [31:0] fepc_q,  fepc_d;
    logic [31:0] fepsw_q, fepsw_d;
    logic [15:0] fecc_q,  fecc_d;
    logic [15:0] eicc_q,  eicc_d;
    logic        nmin_q,  nmin_d;
    logic        nmi_pend_q, nmi_pend_d;

    logic [3:0]  level;
    logic [3:0]  i_next;
    logic        nmi_fall;
    logic        int_ok;
    logic        take_nmi;
    logic        take_int;

    // Arbitration: NMI whenever pending, INT only when unmasked and at or above the mask level.
    always_comb begin
        level    = ~INTVn;
        i_next   = (level == 4'hF) ? 4'hF : level + 4'h1;
        nmi_fall = nmin_q & ~NMIn;
        int_ok   = INT & ~psw_q[NP_BIT] & ~psw_q[EP_BIT] & ~psw_q[ID_BIT]
                   & (level >= psw_q[19:16]);
        take_nmi = CE & BOUNDARY & nmi_pend_q;
        take_int = CE & BOUNDARY & ~nmi_pend_q & int_ok;
        TAKE     = take_nmi | take_int;
        if (take_nmi) begin
            VECTOR = 32'hFFFF_FFD0;
        end else if (take_int) begin
            VECTOR = {24'hFFFFFE, level, 4'h0};
        end else begin
            VECTOR = 32'h0;
        end
    end

    // STSR read mux and RETI target selection.
    always_comb begin
        case (SR_ADDR)
            5'd0:    SR_RDATA = eipc_q;
            5'd1:    SR_RDATA = eipsw_q;
            5'd2:    SR_RDATA = fepc_q;
            5'd3:    SR_RDATA = fepsw_q;
            5'd4:    SR_RDATA = {fecc_q, eicc_q};
            5'd5:    SR_RDATA = psw_q;
            default: SR_RDATA = 32'h0;
        endcase
        RETI_PC = psw_q[NP_BIT] ? fepc_q : eipc_q;
        PSW     = psw_q;
    end

    // Next-state: LDSR first, RETI over it, exception acceptance over everything.
    always_comb begin
        psw_d      = psw_q;
        eipc_d     = eipc_q;
        eipsw_d    = eipsw_q;
        fepc_d     = fepc_q;
        fepsw_d    = fepsw_q;
        fecc_d     = fecc_q;
        eicc_d     = eicc_q;
        nmin_d     = nmin_q;
        nmi_pend_d = nmi_pend_q;
        if (CE) begin
            nmin_d = NMIn;
            if (take_nmi) begin
                nmi_pend_d = 1'b0;
            end
            // A new falling edge on the taking cycle must survive.
            if (nmi_fall) begin
                nmi_pend_d = 1'b1;
            end
            if (SR_WE) begin
                case (SR_ADDR)
                    5'd0:    eipc_d  = SR_WDATA;
                    5'd1:    eipsw_d = SR_WDATA;
                    5'd2:    fepc_d  = SR_WDATA;
                    5'd3:    fepsw_d = SR_WDATA;
                    5'd5:    psw_d   = SR_WDATA & PSW_MASK;
                    default: ;
                endcase
            end
            if (RETI) begin
                psw_d = (psw_q[NP_BIT] ? fepsw_q : eipsw_q) & PSW_MASK;
            end
            if (take_nmi) begin
                fepc_d          = CUR_PC;
                fepsw_d         = psw_q;
                fecc_d          = 16'hFFD0;
                psw_d           = psw_q;
                psw_d[NP_BIT]   = 1'b1;
                psw_d[ID_BIT]   = 1'b1;
                psw_d[AE_BIT]   = 1'b0;
            end else if (take_int) begin
                eipc_d          = CUR_PC;
                eipsw_d         = psw_q;
                eicc_d          = {8'hFE, level, 4'h0};
                psw_d           = psw_q;
                psw_d[EP_BIT]   = 1'b1;
                psw_d[ID_BIT]   = 1'b1;
                psw_d[AE_BIT]   = 1'b0;
                psw_d[19:16]    = i_next;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            psw_q      <= 32'h0000_8000;
            eipc_q     <= 32'h0;
            eipsw_q    <= 32'h0;
            fepc_q     <= 32'h0;
            fepsw_q    <= 32'h0;
            fecc_q     <= 16'h0000;
            eicc_q     <= 16'hFFF0;
            nmin_q     <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            psw_q      <= psw_d;
            eipc_q     <= eipc_d;
            eipsw_q    <= eipsw_d;
            fepc_q     <= fepc_d;
            fepsw_q    <= fepsw_d;
            fecc_q     <= fecc_d;
            eicc_q     <= eicc_d;
            nmin_q     <= nmin_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

endmodule

// File: tb/tb_v810_intc.sv
// tb/tb_v810_intc.sv - scoreboard bench for v810_intc
module tb_v810_intc;

    logic        CLK = 1'b0;
    logic        RESn = 1'b0;
    logic        CE = 1'b1;
    logic        NMIn = 1'b1;
    logic        INT = 1'b0;
    logic [3:0]  INTVn = 4'hF;
    logic        BOUNDARY = 1'b0;
    logic [31:0] CUR_PC = 32'h0;
    logic        SR_WE = 1'b0;
    logic [4:0]  SR_ADDR = 5'd0;
    logic [31:0] SR_WDATA = 32'h0;
    logic [31:0] SR_RDATA;
    logic        RETI = 1'b0;
    logic [31:0] RETI_PC;
    logic        TAKE;
    logic [31:0] VECTOR;
    logic [31:0] PSW;

    typedef struct {
        logic [31:0] vec;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   take_cnt = 0;

    v810_intc dut (
        .CLK(CLK), .RESn(RESn), .CE(CE), .NMIn(NMIn), .INT(INT), .INTVn(INTVn),
        .BOUNDARY(BOUNDARY), .CUR_PC(CUR_PC), .SR_WE(SR_WE), .SR_ADDR(SR_ADDR),
        .SR_WDATA(SR_WDATA), .SR_RDATA(SR_RDATA), .RETI(RETI), .RETI_PC(RETI_PC),
        .TAKE(TAKE), .VECTOR(VECTOR), .PSW(PSW)
    );

    always #10 CLK = ~CLK;

    // Scoreboard: every TAKE pops one expected acceptance.
    always @(negedge CLK) begin
        if (RESn && TAKE) begin
            exp_t e;
            take_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_take vector=%08h pc=%08h", VECTOR, CUR_PC);
            end else begin
                e = exp_q.pop_front();
                if (VECTOR !== e.vec || CUR_PC !== e.pc)
                    $display("FAIL take_vector got %08h/%08h expected %08h/%08h",
                             VECTOR, CUR_PC, e.vec, e.pc);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESn = 1'b0; CE = 1'b1; NMIn = 1'b1; INT = 1'b0; INTVn = 4'hF;
        BOUNDARY = 1'b0; CUR_PC = 32'h0; SR_WE = 1'b0; RETI = 1'b0;
        exp_q.delete();
        tick();
        tick();
        RESn = 1'b1;
        tick();
    endtask

    task automatic ldsr(input logic [4:0] a, input logic [31:0] d);
        SR_WE = 1'b1; SR_ADDR = a; SR_WDATA = d;
        tick();
        SR_WE = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        SR_ADDR = a;
        #1;
        d = SR_RDATA;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        int t0;
        do_reset();
        t0 = take_cnt;
        repeat (20) tick();
        checks++; if (PSW !== 32'h0000_8000) $display("FAIL reset_psw got %08h expected 00008000", PSW); else passed++;
        rd(5'd4, v);
        checks++; if (v !== 32'h0000_FFF0) $display("FAIL reset_ecr got %08h expected 0000fff0", v); else passed++;
        rd(5'd0, v);
        checks++; if (v !== 32'h0) $display("FAIL reset_eipc got %08h expected 0", v); else passed++;
        checks++; if (take_cnt !== t0) $display("FAIL reset_take got %0d expected %0d", take_cnt, t0); else passed++;
        checks++; if (VECTOR !== 32'h0) $display("FAIL reset_vector got %08h expected 0", VECTOR); else passed++;
    endtask

    task automatic test_nmi_offsets();
        logic [31:0] v;
        int t0;
        exp_t e;
        for (int off = 0; off < 30; off++) begin
            do_reset();
            BOUNDARY = 1'b1;
            CUR_PC = 32'h8000_0002;
            t0 = take_cnt;
            repeat (off) tick();
            e.vec = 32'hFFFF_FFD0; e.pc = 32'h8000_0002;
            exp_q.push_back(e);
            NMIn = 1'b0;
            tick();
            NMIn = 1'b1;
            repeat (8) tick();
            checks++; if (take_cnt - t0 !== 1) $display("FAIL nmi_take_count off=%0d got %0d expected 1", off, take_cnt - t0); else passed++;
            checks++; if (PSW !== 32'h0000_9000) $display("FAIL nmi_psw off=%0d got %08h expected 00009000", off, PSW); else passed++;
            rd(5'd4, v);
            checks++; if (v !== 32'hFFD0_FFF0) $display("FAIL nmi_ecr off=%0d got %08h expected ffd0fff0", off, v); else passed++;
            rd(5'd2, v);
            checks++; if (v !== 32'h8000_0002) $display("FAIL nmi_fepc off=%0d got %08h expected 80000002", off, v); else passed++;
        end
    endtask

    task automatic test_int_accept();
        logic [31:0] v;
        int t0;
        exp_t e;
        do_reset();
        ldsr(5'd5, 32'h0008_0000);
        t0 = take_cnt;
        CUR_PC = 32'h0000_1234;
        INTVn = ~4'd8;
        e.vec = 32'hFFFF_FE80; e.pc = 32'h0000_1234;
        exp_q.push_back(e);
        INT = 1'b1; BOUNDARY = 1'b1;
        tick();
        tick();
        checks++; if (PSW !== 32'h0009_5000) $display("FAIL int_psw got %08h expected 00095000", PSW); else passed++;
        rd(5'd1, v);
        checks++; if (v !== 32'h0008_0000) $display("FAIL int_eipsw got %08h expected 00080000", v); else passed++;
        rd(5'd4, v);
        checks++; if (v !== 32'h0000_FE80) $display("FAIL int_ecr got %08h expected 0000fe80", v); else passed++;
        rd(5'd0, v);
        checks++; if (v !== 32'h0000_1234) $display("FAIL int_eipc got %08h expected 00001234", v); else passed++;
        // Still requesting, now at level 15: EP/ID must block a second acceptance.
        INTVn = 4'h0;
        repeat (10) tick();
        checks++; if (take_cnt - t0 !== 1) $display("FAIL int_single_take got %0d expected 1", take_cnt - t0); else passed++;
        INT = 1'b0;
        checks++; if (RETI_PC !== 32'h0000_1234) $display("FAIL reti_pc got %08h expected 00001234", RETI_PC); else passed++;
        RETI = 1'b1;
        tick();
        RETI = 1'b0;
        checks++; if (PSW !== 32'h0008_0000) $display("FAIL reti_psw got %08h expected 00080000", PSW); else passed++;
    endtask

    task automatic test_int_masked();
        logic [31:0] v;
        int t0;
        do_reset();
        ldsr(5'd5, 32'h0008_0000);
        t0 = take_cnt;
        INTVn = ~4'd7; INT = 1'b1; BOUNDARY = 1'b1;
        repeat (30) tick();
        INT = 1'b0;
        checks++; if (take_cnt !== t0) $display("FAIL masked_take got %0d expected %0d", take_cnt, t0); else passed++;
        checks++; if (PSW !== 32'h0008_0000) $display("FAIL masked_psw got %08h expected 00080000", PSW); else passed++;
        rd(5'd1, v);
        checks++; if (v !== 32'h0) $display("FAIL masked_eipsw got %08h expected 0", v); else passed++;
        rd(5'd4, v);
        checks++; if (v !== 32'h0000_FFF0) $display("FAIL masked_ecr got %08h expected 0000fff0", v); else passed++;
    endtask

    task automatic test_nmi_int_priority();
        logic [31:0] v;
        int t0;
        exp_t e;
        do_reset();
        ldsr(5'd5, 32'h0);
        t0 = take_cnt;
        INTVn = 4'h0; INT = 1'b1; CUR_PC = 32'h0000_4000;
        NMIn = 1'b0;
        tick();
        NMIn = 1'b1;
        e.vec = 32'hFFFF_FFD0; e.pc = 32'h0000_4000;
        exp_q.push_back(e);
        BOUNDARY = 1'b1;
        repeat (10) tick();
        INT = 1'b0;
        checks++; if (take_cnt - t0 !== 1) $display("FAIL prio_take_count got %0d expected 1", take_cnt - t0); else passed++;
        checks++; if (PSW !== 32'h0000_9000) $display("FAIL prio_psw got %08h expected 00009000", PSW); else passed++;
        rd(5'd4, v);
        checks++; if (v !== 32'hFFD0_FFF0) $display("FAIL prio_ecr got %08h expected ffd0fff0", v); else passed++;
    endtask

    task automatic test_ldsr();
        logic [31:0] v;
        do_reset();
        ldsr(5'd0, 32'h1111_1111);
        ldsr(5'd1, 32'h2222_2222);
        ldsr(5'd2, 32'h3333_3333);
        ldsr(5'd3, 32'h4444_4444);
        ldsr(5'd4, 32'h5555_5555);
        ldsr(5'd5, 32'hFFFF_FFFF);
        CE = 1'b0;
        ldsr(5'd0, 32'hDEAD_BEEF);
        CE = 1'b1;
        rd(5'd0, v);
        checks++; if (v !== 32'h1111_1111) $display("FAIL ldsr_eipc got %08h expected 11111111", v); else passed++;
        rd(5'd1, v);
        checks++; if (v !== 32'h2222_2222) $display("FAIL ldsr_eipsw got %08h expected 22222222", v); else passed++;
        rd(5'd3, v);
        checks++; if (v !== 32'h4444_4444) $display("FAIL ldsr_fepsw got %08h expected 44444444", v); else passed++;
        rd(5'd4, v);
        checks++; if (v !== 32'h0000_FFF0) $display("FAIL ldsr_ecr got %08h expected 0000fff0", v); else passed++;
        rd(5'd5, v);
        checks++; if (v !== 32'h000F_F000) $display("FAIL ldsr_psw got %08h expected 000ff000", v); else passed++;
        rd(5'd6, v);
        checks++; if (v !== 32'h0) $display("FAIL ldsr_unlisted got %08h expected 0", v); else passed++;
        checks++; if (RETI_PC !== 32'h3333_3333) $display("FAIL ldsr_reti_pc_np got %08h expected 33333333", RETI_PC); else passed++;
        RETI = 1'b1;
        tick();
        RETI = 1'b0;
        checks++; if (PSW !== 32'h0004_4000) $display("FAIL reti_fepsw got %08h expected 00044000", PSW); else passed++;
        checks++; if (RETI_PC !== 32'h1111_1111) $display("FAIL reti_pc_ep got %08h expected 11111111", RETI_PC); else passed++;
    endtask

    initial begin
        test_reset();
        test_nmi_offsets();
        test_int_accept();
        test_int_masked();
        test_nmi_int_priority();
        test_ldsr();
        tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL missing_take got %0d pending expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/v810_intc.md
Name: v810_intc

Overview:
- Interrupt/exception controller and system-register file for the V810 CPU core.
- Sits between the external NMIn/INT/INTVn pins and the execute stage.
- Samples the pins, arbitrates NMI and maskable interrupts at instruction boundaries, and tells the pipeline to flush and vector.
- Holds PSW, EIPC, EIPSW, FEPC, FEPSW and ECR, and services LDSR/STSR/RETI.

Parameters:
- none

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESn  in  1  asynchronous active-low reset.
- CE  in  1  clock enable; no state change when 0.
- NMIn  in  1  non-maskable interrupt pin, active low, edge-sensitive.
- INT  in  1  maskable interrupt request, active high, level-sensitive.
- INTVn  in  4  inverted interrupt level; level L = ~INTVn.
- BOUNDARY  in  1  execute stage is at an instruction boundary; next PC is on CUR_PC.
- CUR_PC  in  32  PC to save on acceptance (restart address).
- SR_WE  in  1  LDSR write strobe.
- SR_ADDR  in  5  system register number: 0 EIPC, 1 EIPSW, 2 FEPC, 3 FEPSW, 4 ECR, 5 PSW.
- SR_WDATA  in  32  LDSR data.
- SR_RDATA  out  32  STSR data for SR_ADDR (combinational); unlisted numbers read 0.
- RETI  in  1  RETI executing (qualified by CE).
- RETI_PC  out  32  return target: FEPC if PSW.NP, else EIPC.
- TAKE  out  1  exception accepted this cycle; pipeline flushes and fetches VECTOR.
- VECTOR  out  32  handler address.
- PSW  out  32  current PSW.

Behaviour:
- PSW fields:
  - bit 12 ID (interrupt disable)
  - bit 13 AE
  - bit 14 EP (exception pending)
  - bit 15 NP (NMI pending)
  - bits 19:16 I (interrupt mask level)
  - other bits are read 0, write ignored.
- ECR: [31:16] FECC, [15:0] EICC.
- Reset (RESn low, asynchronous):
  - PSW=0x00008000.
  - ECR=0x0000FFF0.
  - EIPC=EIPSW=FEPC=FEPSW=0.
  - NMI pending flag cleared.
  - TAKE=0.
- NMI detection:
  - NMIn is registered each CE cycle.
  - A high-to-low transition sets the pending flag.
  - The flag is cleared only when the NMI is taken or on reset.
  - A one-cycle pulse is never lost.
- INT: level L is sampled combinationally each cycle. INT deasserted before acceptance means no interrupt.
- Acceptance (TAKE=1) occurs only when CE & BOUNDARY, with priority NMI > INT.
- NMI is taken whenever its flag is pending. It is not masked by ID/EP/NP. On the same edge:
  - FEPC<=CUR_PC, FEPSW<=PSW.
  - FECC<=0xFFD0.
  - PSW.NP<=1, PSW.ID<=1, AE<=0.
  - VECTOR=0xFFFFFFD0.
- INT is taken when INT=1 & ~NP & ~EP & ~ID & L>=PSW.I. On the same edge:
  - EIPC<=CUR_PC, EIPSW<=PSW.
  - EICC<=0xFE00|(L<<4).
  - PSW.EP<=1, PSW.ID<=1, AE<=0.
  - PSW.I<=L+1, saturating at 15.
  - VECTOR=0xFFFFFE00|(L<<4).
- When TAKE=0, VECTOR=0.
- LDSR:
  - SR_WE writes the addressed register on the edge.
  - Writes to ECR are ignored.
  - PSW writes are masked to the defined fields.
  - If LDSR and TAKE coincide, TAKE's updates win for every register it touches.
- RETI on the edge:
  - If NP: PSW<=FEPSW (masked).
  - Else: PSW<=EIPSW (masked).
  - RETI and TAKE never coincide; the pipeline guarantees this. If they do, TAKE wins.
- Latency: the pin-to-flag edge for NMI is one CE cycle. TAKE is combinational from pending state and BOUNDARY.
- Reset asserted mid-operation discards the pending NMI and any in-progress acceptance.

Test Plan:
- Release reset, idle 20 cycles -> PSW=0x00008000, ECR=0x0000FFF0, TAKE never asserted.
- Release reset, pulse NMIn low for 1 cycle at offsets 0..29, BOUNDARY held high, CUR_PC=0x80000002 -> exactly one TAKE, VECTOR=0xFFFFFFD0, PSW=0x00009000, FECC=0xFFD0, EICC=0xFFF0, FEPC=0x80000002.
- LDSR PSW=0x00080000, then INT=1 with L=8 held -> TAKE, VECTOR=0xFFFFFE80, PSW=0x00095000, EIPSW=0x00080000, EICC=0xFE80, FECC=0, EIPC=CUR_PC.
- PSW=0x00080000, INT=1 with L=7 held 30 cycles -> no TAKE, PSW unchanged, EIPSW=0, EICC=0xFFF0.
- After INT8 acceptance, keep INT asserted with L=15 -> no second TAKE (EP/ID set). Then RETI -> PSW=0x00080000, RETI_PC=EIPC.
- NMI pending and INT L=15 on the same boundary -> NMI taken first. With NP now set, the INT is not taken.
